// File: rtl/bram_fifo_ctrl.sv
`timescale 1ns/1ps
// bram_fifo_ctrl: ready/valid FIFO over a dual-port BRAM with a 2-slot output buffer; BRAM_FIFO_CTRL_COUNT_EN adds the COUNT port
module bram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] RAM_DI,
  output logic [ADDR_WIDTH-1:0] RAM_WR_ADDR,
  output logic                  RAM_WE,
  output logic [ADDR_WIDTH-1:0] RAM_RD_ADDR,
  input  logic [DATA_WIDTH-1:0] RAM_DO
`ifdef BRAM_FIFO_CTRL_COUNT_EN
  ,
  output logic [ADDR_WIDTH+1:0] COUNT
`endif
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_count;
  logic                  r_pend;
  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_buf0, r_buf1;
  logic                  w_enq, w_deq, w_rd_issue;
  logic [1:0]            w_occ_left;
  assign IN_READY    = !RST && r_ram_count != DEPTH;
  assign OUT_VALID   = !RST && r_occ != 2'd0;
  assign OUT_DATA    = r_buf0;
  assign w_enq       = IN_VALID && IN_READY;
  assign w_deq       = OUT_VALID && OUT_READY;
  // buffer occupancy once this cycle's pop is done, before the in-flight word lands
  assign w_occ_left  = r_occ - {1'b0, w_deq};
  assign w_rd_issue  = !RST && r_ram_count != '0 && (w_occ_left + {1'b0, r_pend}) < 2'd2;
  assign RAM_DI      = IN_DATA;
  assign RAM_WE      = w_enq;
  assign RAM_WR_ADDR = r_wr_ptr;
  assign RAM_RD_ADDR = r_rd_ptr;
`ifdef BRAM_FIFO_CTRL_COUNT_EN
  assign COUNT = RST ? '0 : {1'b0, r_ram_count} + (ADDR_WIDTH+2)'(r_pend) + (ADDR_WIDTH+2)'(r_occ);
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_count <= '0;
      r_pend      <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ram_count <= r_ram_count + (ADDR_WIDTH+1)'(w_enq) - (ADDR_WIDTH+1)'(w_rd_issue);
      r_pend      <= w_rd_issue;
      r_occ       <= w_occ_left + {1'b0, r_pend};
    end
  end
  always_ff @(posedge CLK) begin
    if (r_occ == 2'd0 || w_deq) r_buf0 <= (r_occ == 2'd2) ? r_buf1 : RAM_DO;
    if (r_pend && w_occ_left == 2'd1) r_buf1 <= RAM_DO;
  end
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
`timescale 1ns/1ps
// tb_bram_fifo_ctrl: bench for bram_fifo_ctrl with a behavioural BRAM and a queue scoreboard
module tb_bram_fifo_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam logic [DW-1:0] POISON = 32'hBAD0_BAD0;
  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] IN_DATA;
  logic          IN_VALID;
  logic          IN_READY;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [DW-1:0] RAM_DI;
  logic [AW-1:0] RAM_WR_ADDR;
  logic          RAM_WE;
  logic [AW-1:0] RAM_RD_ADDR;
  logic [DW-1:0] RAM_DO;
`ifdef BRAM_FIFO_CTRL_COUNT_EN
  logic [AW+1:0] COUNT;
`endif
  always #5 CLK = ~CLK;
  bram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RAM_DI(RAM_DI), .RAM_WR_ADDR(RAM_WR_ADDR), .RAM_WE(RAM_WE),
    .RAM_RD_ADDR(RAM_RD_ADDR), .RAM_DO(RAM_DO)
`ifdef BRAM_FIFO_CTRL_COUNT_EN
    , .COUNT(COUNT)
`endif
  );
  // BRAM with registered read; a same-address read/write returns a poison word
  logic [DW-1:0] mem [2**AW];
  always @(posedge CLK) begin
    if (RAM_WE) mem[RAM_WR_ADDR] <= RAM_DI;
    RAM_DO <= (RAM_WE && RAM_WR_ADDR == RAM_RD_ADDR) ? POISON : mem[RAM_RD_ADDR];
  end
  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] sb[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge CLK) if (IN_VALID && IN_READY) sb.push_back(IN_DATA);
  always @(negedge CLK)
    if (OUT_VALID && OUT_READY) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
      else chk("out_data", 64'(OUT_DATA), 64'(sb.pop_front()));
    end
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic drain();
    for (int b = 0; b < 100 && sb.size() != 0; b++) cyc();
    repeat (4) cyc();
  endtask
  int acc, gaps;
  initial begin
    RST = 1'b1;
    IN_VALID = 1'b1;
    IN_DATA = 32'h11;
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_we", RAM_WE, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    cyc();
    cyc();
    RST = 1'b0;
    IN_VALID = 1'b0;
    @(negedge CLK);
    chk("post_rst_in_ready", IN_READY, 1);
    chk("post_rst_out_valid", OUT_VALID, 0);
`ifdef BRAM_FIFO_CTRL_COUNT_EN
    chk("post_rst_count", COUNT, 0);
`endif
    cyc();
    IN_VALID = 1'b1;
    IN_DATA = 32'hA5;
    @(negedge CLK);
    chk("sw_accept", IN_READY, 1);
    cyc();
    IN_VALID = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      chk($sformatf("sw_valid_c%0d", k), OUT_VALID, k == 3);
      if (k == 3) chk("sw_data", OUT_DATA, 32'hA5);
      cyc();
    end
    OUT_READY = 1'b0;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      IN_VALID = 1'b1;
      IN_DATA = acc;
      @(negedge CLK);
      if (IN_READY) acc++;
      cyc();
    end
    IN_VALID = 1'b0;
    chk("fill_accepted", acc, 18);
    @(negedge CLK);
    chk("fill_in_ready", IN_READY, 0);
`ifdef BRAM_FIFO_CTRL_COUNT_EN
    chk("fill_count", COUNT, 18);
`endif
    cyc();
    OUT_READY = 1'b1;
    drain();
    @(negedge CLK);
    chk("fill_drain_empty", sb.size(), 0);
    chk("fill_in_ready_back", IN_READY, 1);
    chk("fill_out_valid_end", OUT_VALID, 0);
    cyc();
    acc = 0;
    gaps = 0;
    for (int i = 0; i < 1003; i++) begin
      IN_VALID = i < 1000;
      IN_DATA = 1000 + i;
      @(negedge CLK);
      if (IN_VALID && IN_READY) acc++;
      if (i >= 3 && !OUT_VALID) gaps++;
      cyc();
    end
    IN_VALID = 1'b0;
    chk("stream_accepted", acc, 1000);
    chk("stream_gaps", gaps, 0);
    @(negedge CLK);
    chk("stream_end_valid", OUT_VALID, 0);
    cyc();
    for (int i = 0; i < 10000; i++) begin
      IN_VALID = 1'($urandom);
      IN_DATA = $urandom;
      if (IN_DATA == POISON) IN_DATA = ~POISON;
      OUT_READY = 1'($urandom);
      cyc();
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    drain();
    @(negedge CLK);
    chk("rand_drain_empty", sb.size(), 0);
    chk("rand_out_valid_end", OUT_VALID, 0);
    cyc();
    OUT_READY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      IN_VALID = 1'b1;
      IN_DATA = 32'h100 + i;
      cyc();
    end
    IN_VALID = 1'b0;
    repeat (4) cyc();
    @(negedge CLK);
    chk("rm_held_valid", OUT_VALID, 1);
`ifdef BRAM_FIFO_CTRL_COUNT_EN
    chk("rm_held_count", COUNT, 10);
`endif
    cyc();
    OUT_READY = 1'b1;
    cyc();
    OUT_READY = 1'b0;
    RST = 1'b1;
    sb.delete();
    @(negedge CLK);
    chk("rm_rst_valid", OUT_VALID, 0);
    chk("rm_rst_in_ready", IN_READY, 0);
    cyc();
    RST = 1'b0;
    IN_VALID = 1'b1;
    IN_DATA = 32'h3C;
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("rm_after_valid", OUT_VALID, 0);
    chk("rm_after_in_ready", IN_READY, 1);
`ifdef BRAM_FIFO_CTRL_COUNT_EN
    chk("rm_after_count", COUNT, 0);
`endif
    cyc();
    IN_VALID = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      chk($sformatf("rm_valid_c%0d", k), OUT_VALID, k == 3);
      if (k == 3) chk("rm_data", OUT_DATA, 32'h3C);
      cyc();
    end
    chk("rm_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
